// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display encoder/decoder pair.
// Holds segment bit positions, reserved code values, the character table
// (code -> 7-bit {G,F,E,D,C,B,A} pattern) and the payload types used on the
// readback/commit paths. Both directions use char_pattern() so they agree.
package display_pkg;

    localparam int unsigned SEG_W   = 8;   // {dot,G,F,E,D,C,B,A}
    localparam int unsigned PAT_W   = 7;   // segments without dot
    localparam int unsigned CODE_W  = 6;

    localparam int unsigned SEG_A   = 0;
    localparam int unsigned SEG_B   = 1;
    localparam int unsigned SEG_C   = 2;
    localparam int unsigned SEG_D   = 3;
    localparam int unsigned SEG_E   = 4;
    localparam int unsigned SEG_F   = 5;
    localparam int unsigned SEG_G   = 6;
    localparam int unsigned SEG_DOT = 7;

    localparam logic [CODE_W-1:0] CODE_BLANK   = 6'd0;
    localparam logic [CODE_W-1:0] CODE_DASH    = 6'd38;
    localparam logic [CODE_W-1:0] CODE_UNKNOWN = 6'd63;
    localparam int unsigned       CODE_MAX     = 38;

    typedef enum logic {
        ACQ,
        LOCKED
    } track_state_e;

    // One stored digit: matches the {dot,code} readback format.
    typedef struct packed {
        logic              dot;
        logic [CODE_W-1:0] code;
    } cell_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              unknown;
    } lookup_t;

    // Character table: 1..10 digits '0'..'9', 11..36 letters 'A'..'Z',
    // 37 '_', 38 '-'. Some letters share a glyph with a digit or another
    // letter; the decoder resolves those to the lowest code.
    function automatic logic [PAT_W-1:0] char_pattern(input logic [CODE_W-1:0] code);
        logic [PAT_W-1:0] p;
        case (code)
            6'd1:  p = 7'h3F;  6'd2:  p = 7'h06;  6'd3:  p = 7'h5B;  6'd4:  p = 7'h4F;
            6'd5:  p = 7'h66;  6'd6:  p = 7'h6D;  6'd7:  p = 7'h7D;  6'd8:  p = 7'h07;
            6'd9:  p = 7'h7F;  6'd10: p = 7'h6F;
            6'd11: p = 7'h77;  6'd12: p = 7'h7C;  6'd13: p = 7'h39;  6'd14: p = 7'h5E;
            6'd15: p = 7'h79;  6'd16: p = 7'h71;  6'd17: p = 7'h3D;  6'd18: p = 7'h76;
            6'd19: p = 7'h30;  6'd20: p = 7'h1E;  6'd21: p = 7'h75;  6'd22: p = 7'h38;
            6'd23: p = 7'h37;  6'd24: p = 7'h54;  6'd25: p = 7'h5C;  6'd26: p = 7'h73;
            6'd27: p = 7'h67;  6'd28: p = 7'h50;  6'd29: p = 7'h6D;  6'd30: p = 7'h78;
            6'd31: p = 7'h1C;  6'd32: p = 7'h1C;  6'd33: p = 7'h2A;  6'd34: p = 7'h76;
            6'd35: p = 7'h6E;  6'd36: p = 7'h5B;
            6'd37: p = 7'h08;  6'd38: p = 7'h40;
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/display_segment_to_char_if.sv
// Segment-bus monitor interface.
//  sample_en/digit_sel/segments : multiplexed display bus being observed
//  valid/code/dot/digit/err     : change report for a committed digit
//  rd_digit/rd_code             : readback of the per-digit code store
// master drives the bus and readback index; slave is the monitor.
interface display_segment_to_char_if
    import display_pkg::*;
#(
    parameter int unsigned DIGIT_W = 2
);
    logic                sample_en;
    logic [DIGIT_W-1:0]  digit_sel;
    logic [SEG_W-1:0]    segments;
    logic                valid;
    logic [CODE_W-1:0]   code;
    logic                dot;
    logic [DIGIT_W-1:0]  digit;
    logic                err;
    logic [DIGIT_W-1:0]  rd_digit;
    logic [CODE_W:0]     rd_code;

    modport master (
        output sample_en, digit_sel, segments, rd_digit,
        input  valid, code, dot, digit, err, rd_code
    );

    modport slave (
        input  sample_en, digit_sel, segments, rd_digit,
        output valid, code, dot, digit, err, rd_code
    );
endinterface

// File: rtl/display_segment_lookup.sv
// Combinational reverse lookup of a 7-bit segment pattern into a character
// code. All-off decodes to blank; patterns not in the table decode to
// CODE_UNKNOWN with unknown=1.
//  pattern : {G,F,E,D,C,B,A}
//  result  : {code, unknown}
module display_segment_lookup
    import display_pkg::*;
(
    input  logic [PAT_W-1:0] pattern,
    output lookup_t          result
);

    // Scan from the top so the lowest matching code is the one that sticks.
    always_comb begin
        result.code    = CODE_UNKNOWN;
        result.unknown = 1'b1;
        if (pattern == '0) begin
            result.code    = CODE_BLANK;
            result.unknown = 1'b0;
        end else begin
            for (int i = int'(CODE_MAX); i >= 1; i--) begin
                if (char_pattern(CODE_W'(i)) == pattern) begin
                    result.code    = CODE_W'(i);
                    result.unknown = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/display_segment_to_char.sv
// Display readback monitor: debounces the time-multiplexed segment bus,
// decodes stable patterns back into character codes, keeps a per-digit
// {dot,code} store and reports store changes.
//  clk, rst : clock, asynchronous active-high reset
//  bus      : slave side of display_segment_to_char_if (sample inputs,
//             change report outputs, readback index/data)
module display_segment_to_char
    import display_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned DIGIT_W    = 2,
    parameter int unsigned STABLE_CNT = 3
) (
    input logic                      clk,
    input logic                      rst,
    display_segment_to_char_if.slave bus
);

    localparam int unsigned CNT_W    = $clog2(STABLE_CNT + 1);
    localparam int unsigned SAMPLE_W = DIGIT_W + SEG_W;

    track_state_e          state_q, state_d;
    logic [SAMPLE_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  commit_c;

    logic [SAMPLE_W-1:0]   sample_c;
    logic                  in_range_c;
    lookup_t               lk_c;
    cell_t                 new_cell_c;
    logic                  changed_c;

    cell_t                 store_q [DIGITS];
    cell_t                 rd_code_q;
    logic                  valid_q;
    logic [CODE_W-1:0]     code_q;
    logic                  dot_q;
    logic [DIGIT_W-1:0]    digit_q;
    logic                  err_q;

    assign sample_c   = {bus.digit_sel, bus.segments};
    assign in_range_c = 32'(bus.digit_sel) < DIGITS;

    display_segment_lookup u_lookup (
        .pattern (bus.segments[PAT_W-1:0]),
        .result  (lk_c)
    );

    assign new_cell_c = '{dot: bus.segments[SEG_DOT], code: lk_c.code};
    // Commits that would not alter the store are silent.
    assign changed_c  = commit_c && (store_q[bus.digit_sel] != new_cell_c);

    // Tracker state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACQ;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Tracker next state: count consecutive identical samples, commit once.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        commit_c = 1'b0;
        if (bus.sample_en) begin
            if (!in_range_c) begin
                // Out-of-range digit: remember it but never let it count.
                last_d  = sample_c;
                cnt_d   = '0;
                state_d = ACQ;
            end else if (sample_c != last_q) begin
                last_d = sample_c;
                cnt_d  = CNT_W'(1);
                if (STABLE_CNT == 1) begin
                    commit_c = 1'b1;
                    state_d  = LOCKED;
                end else begin
                    state_d = ACQ;
                end
            end else if (state_q == ACQ) begin
                if (cnt_q >= CNT_W'(STABLE_CNT - 1)) begin
                    cnt_d    = CNT_W'(STABLE_CNT);
                    commit_c = 1'b1;
                    state_d  = LOCKED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Code store and change report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                store_q[i] <= '0;
            end
            valid_q <= 1'b0;
            code_q  <= '0;
            dot_q   <= 1'b0;
            digit_q <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= changed_c;
            err_q   <= changed_c && lk_c.unknown;
            if (changed_c) begin
                store_q[bus.digit_sel] <= new_cell_c;
                code_q  <= new_cell_c.code;
                dot_q   <= new_cell_c.dot;
                digit_q <= bus.digit_sel;
            end
        end
    end

    // Readback with write bypass so a same-cycle commit is visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_code_q <= '0;
        end else if (32'(bus.rd_digit) >= DIGITS) begin
            rd_code_q <= '0;
        end else if (changed_c && (bus.rd_digit == bus.digit_sel)) begin
            rd_code_q <= new_cell_c;
        end else begin
            rd_code_q <= store_q[bus.rd_digit];
        end
    end

    assign bus.valid   = valid_q;
    assign bus.code    = code_q;
    assign bus.dot     = dot_q;
    assign bus.digit   = digit_q;
    assign bus.err     = err_q;
    assign bus.rd_code = rd_code_q;

endmodule

// File: tb/tb_display_segment_to_char.sv
// Scoreboard bench for display_segment_to_char (DIGITS=3 so an
// out-of-range digit select is reachable).
module tb_display_segment_to_char;

    typedef struct packed {
        logic [5:0] code;
        logic       dot;
        logic [1:0] digit;
        logic       err;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    exp_t mon_exp;
    exp_t mon_got;

    display_segment_to_char_if #(.DIGIT_W(2)) bus ();

    display_segment_to_char #(
        .DIGITS     (3),
        .DIGIT_W    (2),
        .STABLE_CNT (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // One sample strobe, then a gap cycle with garbage on the bus.
    task automatic strobe(input logic [1:0] d, input logic [7:0] seg);
        @(negedge clk);
        bus.sample_en = 1'b1;
        bus.digit_sel = d;
        bus.segments  = seg;
        @(negedge clk);
        bus.sample_en = 1'b0;
        bus.digit_sel = 2'(~d);
        bus.segments  = 8'hA5;
    endtask

    task automatic expect_commit(input logic [5:0] c, input logic dt, input logic [1:0] d, input logic e);
        exp_t x;
        x.code  = c;
        x.dot   = dt;
        x.digit = d;
        x.err   = e;
        exp_q.push_back(x);
    endtask

    task automatic read_check(input logic [1:0] d, input logic [6:0] req, input string name);
        @(negedge clk);
        bus.rd_digit = d;
        @(negedge clk);
        check(name, 32'(bus.rd_code), 32'(req));
    endtask

    // Monitor: every valid pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (!rst && bus.valid) begin
            checks++;
            mon_got.code  = bus.code;
            mon_got.dot   = bus.dot;
            mon_got.digit = bus.digit;
            mon_got.err   = bus.err;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid actual code=%0d dot=%0d digit=%0d err=%0d required no valid",
                         mon_got.code, mon_got.dot, mon_got.digit, mon_got.err);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL commit actual code=%0d dot=%0d digit=%0d err=%0d required code=%0d dot=%0d digit=%0d err=%0d",
                             mon_got.code, mon_got.dot, mon_got.digit, mon_got.err,
                             mon_exp.code, mon_exp.dot, mon_exp.digit, mon_exp.err);
                end
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.sample_en = 1'b0;
        bus.digit_sel = '0;
        bus.segments  = '0;
        bus.rd_digit  = '0;
        repeat (3) @(negedge clk);
        check("rst_valid",   32'(bus.valid),   32'd0);
        check("rst_code",    32'(bus.code),    32'd0);
        check("rst_dot",     32'(bus.dot),     32'd0);
        check("rst_digit",   32'(bus.digit),   32'd0);
        check("rst_err",     32'(bus.err),     32'd0);
        check("rst_rd_code", 32'(bus.rd_code), 32'd0);
        rst = 1'b0;

        // '0' on digit 2; valid exactly one cycle after the third strobe.
        strobe(2'd2, 8'h3F);
        strobe(2'd2, 8'h3F);
        expect_commit(6'd1, 1'b0, 2'd2, 1'b0);
        strobe(2'd2, 8'h3F);
        check("t1_latency", 32'(bus.valid), 32'd1);

        // '5' with dot on digit 1; repeats and silent re-commits give nothing.
        strobe(2'd1, 8'hED);
        strobe(2'd1, 8'hED);
        expect_commit(6'd6, 1'b1, 2'd1, 1'b0);
        strobe(2'd1, 8'hED);
        repeat (3) strobe(2'd1, 8'hED);
        repeat (3) strobe(2'd2, 8'h3F);
        repeat (3) strobe(2'd1, 8'hED);
        read_check(2'd1, 7'h46, "t2_rd_digit1");
        read_check(2'd2, 7'h01, "t2_rd_digit2");

        // Debounce restart: only the stable '1' commits.
        strobe(2'd0, 8'h3F);
        strobe(2'd0, 8'h3F);
        strobe(2'd0, 8'h06);
        strobe(2'd0, 8'h06);
        expect_commit(6'd2, 1'b0, 2'd0, 1'b0);
        strobe(2'd0, 8'h06);

        // Unknown, duplicate-glyph, dash, blank, dot-only change.
        repeat (2) strobe(2'd0, 8'h7E);
        expect_commit(6'd63, 1'b0, 2'd0, 1'b1);
        strobe(2'd0, 8'h7E);
        repeat (2) strobe(2'd0, 8'h1C);
        expect_commit(6'd31, 1'b0, 2'd0, 1'b0);
        strobe(2'd0, 8'h1C);
        repeat (2) strobe(2'd0, 8'h40);
        expect_commit(6'd38, 1'b0, 2'd0, 1'b0);
        strobe(2'd0, 8'h40);
        repeat (2) strobe(2'd0, 8'h00);
        expect_commit(6'd0, 1'b0, 2'd0, 1'b0);
        strobe(2'd0, 8'h00);
        repeat (2) strobe(2'd2, 8'hBF);
        expect_commit(6'd1, 1'b1, 2'd2, 1'b0);
        strobe(2'd2, 8'hBF);
        read_check(2'd0, 7'h00, "t4_rd_blank");

        // Interleaved digits break the run; out-of-range digit never commits.
        strobe(2'd0, 8'h5B);
        strobe(2'd1, 8'h5B);
        strobe(2'd0, 8'h5B);
        strobe(2'd0, 8'h5B);
        expect_commit(6'd3, 1'b0, 2'd0, 1'b0);
        strobe(2'd0, 8'h5B);
        repeat (5) strobe(2'd3, 8'h3F);
        read_check(2'd3, 7'h00, "t5_rd_out_of_range");
        read_check(2'd0, 7'h03, "t5_rd_digit0");

        // Reset after two of three matches.
        read_check(2'd2, 7'h41, "t6_rd_before_rst");
        strobe(2'd2, 8'h66);
        strobe(2'd2, 8'h66);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_code",    32'(bus.code),    32'd0);
        check("t6_rst_valid",   32'(bus.valid),   32'd0);
        check("t6_rst_rd_code", 32'(bus.rd_code), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        read_check(2'd0, 7'h00, "t6_store0_cleared");
        read_check(2'd1, 7'h00, "t6_store1_cleared");
        read_check(2'd2, 7'h00, "t6_store2_cleared");
        strobe(2'd2, 8'h66);
        strobe(2'd2, 8'h66);
        expect_commit(6'd5, 1'b0, 2'd2, 1'b0);
        strobe(2'd2, 8'h66);
        check("t6_rd_bypass", 32'(bus.rd_code), 32'h05);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
